// File: rtl/cwe1280_fixed.sv
// Access-controlled data register with a same-cycle write-grant check.
// The grant is derived from the usr_id present at the clock edge that would
// perform the write, so a denied requester never touches the stored asset.
// Denied attempts are counted in a saturating counter for security monitoring.
module cwe1280_fixed #(
  parameter int unsigned                   DATA_W    = 8,
  parameter int unsigned                   ID_W      = 3,
  parameter logic [(2**ID_W)-1:0]          AUTH_MASK = 'h10,
  parameter int unsigned                   CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   usr_id,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              grant_q,
  output logic [CNT_W-1:0]  deny_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Write request as seen on the bus this cycle.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t req;
  logic    grant;
  logic    cnt_sat;

  // Bundle the bus inputs; every cycle out of reset is a write attempt.
  always_comb begin
    req.id   = usr_id;
    req.data = data_in;
  end

  // Grant comes straight from the current ID; no registered ID is ever used,
  // so switching IDs cannot leave a stale grant behind.
  always_comb begin
    grant   = AUTH_MASK[req.id];
    cnt_sat = (deny_cnt == CNT_MAX);
  end

  // Protected asset: only updated when this same cycle's requester is allowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        data_out <= '0;
    else if (grant) data_out <= req.data;
  end

  // Registered copy of the grant decision for observers on the bus side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) grant_q <= 1'b0;
    else     grant_q <= grant;
  end

  // Denied-attempt counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    deny_cnt <= '0;
    else if (!grant && !cnt_sat) deny_cnt <= deny_cnt + 1'b1;
  end

endmodule

// File: tb/tb_cwe1280_fixed.sv
// Scoreboard bench for cwe1280_fixed: the driver pushes expected outputs from a
// behavioural model after each edge; a monitor pops and compares them.
module tb_cwe1280_fixed;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] usr_id;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       grant_q;
  logic [7:0] deny_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int data;
    int grant;
    int cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (plain integers).
  int m_data  = 0;
  int m_grant = 0;
  int m_cnt   = 0;
  int allowed_ids[$] = '{4};

  cwe1280_fixed dut (
    .clk      (clk),
    .rst      (rst),
    .usr_id   (usr_id),
    .data_in  (data_in),
    .data_out (data_out),
    .grant_q  (grant_q),
    .deny_cnt (deny_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int is_allowed(input int id);
    foreach (allowed_ids[i]) if (allowed_ids[i] == id) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    m_data = 0; m_grant = 0; m_cnt = 0;
  endfunction

  // Drive one cycle: inputs change at negedge, model advances at posedge.
  task automatic step(input int id, input int d, input logic r);
    exp_t e;
    @(negedge clk);
    rst = r; usr_id = id[2:0]; data_in = d[7:0];
    @(posedge clk);
    if (r) model_reset();
    else if (is_allowed(id) != 0) begin
      m_data = d; m_grant = 1;
    end else begin
      m_grant = 0;
      m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    end
    e.data = m_data; e.grant = m_grant; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: registered outputs are valid every cycle, checked 1ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_data_out", 32'(data_out), 32'(e.data));
        chk("sb_grant_q",  32'(grant_q),  32'(e.grant));
        chk("sb_deny_cnt", 32'(deny_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    rst = 1'b1; usr_id = '0; data_in = '0;
    #1;
    chk("reset_async_data", 32'(data_out), 0);
    // 1. hold reset with random inputs
    for (int i = 0; i < 4; i++) step($urandom_range(7), $urandom_range(255), 1'b1);
    #2;
    chk("reset_hold_data",  32'(data_out), 0);
    chk("reset_hold_grant", 32'(grant_q),  0);
    chk("reset_hold_cnt",   32'(deny_cnt), 0);

    // 2. authorized write
    step(4, 'hAB, 1'b0);
    #2;
    chk("auth_write_data",  32'(data_out), 'hAB);
    chk("auth_write_grant", 32'(grant_q),  1);
    chk("auth_write_cnt",   32'(deny_cnt), 0);

    // 3./4. unauthorized writes
    step(3, 'hCD, 1'b0);
    #2;
    chk("deny1_data", 32'(data_out), 'hAB);
    chk("deny1_grant", 32'(grant_q), 0);
    chk("deny1_cnt",  32'(deny_cnt), 1);
    step(3, 'hEF, 1'b0);
    #2;
    chk("deny2_data", 32'(data_out), 'hAB);
    chk("deny2_cnt",  32'(deny_cnt), 2);
    for (int i = 0; i < 300; i++) step(3, $urandom_range(255), 1'b0);
    #2;
    chk("deny_saturated", 32'(deny_cnt), 'hFF);
    chk("deny_sat_data",  32'(data_out), 'hAB);

    // 5. switch denied -> authorized, then sweep every ID
    step(4, 'h5A, 1'b0);
    #2;
    chk("switch_data",  32'(data_out), 'h5A);
    chk("switch_grant", 32'(grant_q),  1);
    for (int rep = 0; rep < 4; rep++)
      for (int id = 0; id < 8; id++) step(id, $urandom_range(255), 1'b0);

    // 6. async reset between edges
    step(4, 'h5A, 1'b0);
    #3;
    chk("pre_reset_data", 32'(data_out), 'h5A);
    rst = 1'b1;
    #1;
    chk("midreset_data",  32'(data_out), 0);
    chk("midreset_grant", 32'(grant_q),  0);
    chk("midreset_cnt",   32'(deny_cnt), 0);
    model_reset();

    // Random traffic, biased toward the allowed ID, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      int id;
      id = ($urandom_range(3) == 0) ? 4 : $urandom_range(7);
      step(id, $urandom_range(255), ($urandom_range(99) == 0) ? 1'b1 : 1'b0);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
